// File: rtl/lvds_p2s_if.sv
`default_nettype none
// ============================================================================
// Module   : lvds_p2s_if
// Purpose  : Parallel byte input and serial lane output bundle for the LVDS
//            parallel-to-serial frame transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface lvds_p2s_if #(
   parameter int ADDR_W = 11
);
   logic [8:0]      p2s_din;    // {byte valid, byte}
   logic [3:0]      p2s_dout;   // [3] frame-valid, [0] data, [2:1] zero
   logic            busy;
   logic            tx_done;
   logic [ADDR_W:0] frame_len;
   logic            err_drop;

   modport master (
      output p2s_din,
      input  p2s_dout, busy, tx_done, frame_len, err_drop
   );

   modport slave (
      input  p2s_din,
      output p2s_dout, busy, tx_done, frame_len, err_drop
   );
endinterface
`default_nettype wire

// File: rtl/lvds_p2s.sv
`default_nettype none
// ============================================================================
// Module   : lvds_p2s
// Purpose  : Buffers a frame of valid bytes, then sends it MSB first on a
//            gated serial lane (frame-valid on bit 3, data on bit 0),
//            followed by a fixed idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module lvds_p2s #(
   parameter int MAX_BYTES = 2048,
   parameter int ADDR_W    = 11,
   parameter int GAP_CYC   = 16
) (
   input  wire logic   clk,
   input  wire logic   rstn,
   lvds_p2s_if.slave   bus
);

   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_TX   = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t            r_state;
   logic [ADDR_W:0]   r_wr_cnt;
   logic [ADDR_W:0]   r_frame_len;
   logic [ADDR_W:0]   r_byte;       // index of the byte currently on the lane
   logic [ADDR_W-1:0] r_rd_addr;
   logic [7:0]        r_rd_data;
   logic [7:0]        r_sh;         // output shifter, [7] is the lane bit
   logic              r_txv;
   logic [2:0]        r_bit;
   logic [1:0]        r_pre;        // start-up wait covering the RAM latency
   logic              r_run;
   logic [GAP_W-1:0]  r_gap;
   logic              r_busy;
   logic              r_tx_done;
   logic              r_err_drop;
   logic [7:0]        r_mem [MAX_BYTES];

   logic              w_vld;
   logic              w_full;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic              w_last_byte;

   assign w_vld       = bus.p2s_din[8];
   assign w_full      = (r_wr_cnt == (ADDR_W+1)'(MAX_BYTES));
   // The first byte of a frame is written while still in IDLE, at address 0.
   assign w_we        = w_vld && ((r_state == S_IDLE) ||
                                  ((r_state == S_LOAD) && !w_full));
   assign w_waddr     = (r_state == S_IDLE) ? '0 : r_wr_cnt[ADDR_W-1:0];
   assign w_last_byte = (r_byte == r_frame_len - (ADDR_W+1)'(1));

   // Buffer write port; no reset so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= bus.p2s_din[7:0];
      end
   end

   // Buffer read port with one cycle of latency.
   always_ff @(posedge clk) begin
      r_rd_data <= r_mem[r_rd_addr];
   end

   // Frame state machine: load, serialise MSB first, then hold the idle gap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_wr_cnt    <= '0;
         r_frame_len <= '0;
         r_byte      <= '0;
         r_rd_addr   <= '0;
         r_sh        <= '0;
         r_txv       <= 1'b0;
         r_bit       <= '0;
         r_pre       <= '0;
         r_run       <= 1'b0;
         r_gap       <= '0;
         r_busy      <= 1'b0;
         r_tx_done   <= 1'b0;
         r_err_drop  <= 1'b0;
      end else begin
         r_tx_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_vld) begin
                  r_wr_cnt <= (ADDR_W+1)'(1);
                  r_state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_vld) begin
                  if (w_full) begin
                     r_err_drop <= 1'b1;
                  end else begin
                     r_wr_cnt <= r_wr_cnt + (ADDR_W+1)'(1);
                  end
               end else begin
                  r_frame_len <= r_wr_cnt;
                  r_rd_addr   <= '0;
                  r_pre       <= '0;
                  r_run       <= 1'b0;
                  r_state     <= S_TX;
               end
            end
            S_TX: begin
               if (w_vld) begin
                  r_err_drop <= 1'b1;
               end
               if (!r_run) begin
                  // Two cycles let byte 0 come out of the RAM before the
                  // shifter loads it.
                  if (r_pre == 2'd2) begin
                     r_sh   <= r_rd_data;
                     r_txv  <= 1'b1;
                     r_bit  <= '0;
                     r_byte <= '0;
                     r_run  <= 1'b1;
                  end else begin
                     r_pre <= r_pre + 2'd1;
                     if (r_pre == 2'd0) begin
                        r_busy <= 1'b1;
                     end
                  end
               end else if (r_bit == 3'd7) begin
                  if (w_last_byte) begin
                     r_txv     <= 1'b0;
                     r_sh      <= '0;
                     r_tx_done <= 1'b1;
                     r_run     <= 1'b0;
                     r_gap     <= '0;
                     r_state   <= S_GAP;
                  end else begin
                     r_sh   <= r_rd_data;
                     r_bit  <= r_bit + 3'd1;
                     r_byte <= r_byte + (ADDR_W+1)'(1);
                  end
               end else begin
                  r_sh  <= {r_sh[6:0], 1'b0};
                  r_bit <= r_bit + 3'd1;
                  // Prefetch: next byte is ready long before the boundary.
                  if (r_bit == 3'd2) begin
                     r_rd_addr <= r_rd_addr + ADDR_W'(1);
                  end
               end
            end
            S_GAP: begin
               if (w_vld) begin
                  r_err_drop <= 1'b1;
               end
               if (r_gap == GAP_W'(GAP_CYC - 1)) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_gap <= r_gap + GAP_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.p2s_dout  = {r_txv, 2'b00, r_sh[7]};
   assign bus.busy      = r_busy;
   assign bus.tx_done   = r_tx_done;
   assign bus.frame_len = r_frame_len;
   assign bus.err_drop  = r_err_drop;

endmodule
`default_nettype wire

// File: tb/tb_lvds_p2s.sv
`default_nettype none
// ============================================================================
// Module   : tb_lvds_p2s
// Purpose  : Self-checking bench for lvds_p2s. Expected bytes are queued as
//            frames are driven and compared against bytes rebuilt from the
//            serial lane.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lvds_p2s;

   localparam int MAX_BYTES = 2048;
   localparam int ADDR_W    = 11;
   localparam int GAP_CYC   = 16;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   lvds_p2s_if #(.ADDR_W(ADDR_W)) bus ();

   lvds_p2s #(
      .MAX_BYTES (MAX_BYTES),
      .ADDR_W    (ADDR_W),
      .GAP_CYC   (GAP_CYC)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [7:0] q_exp [$];
   logic [7:0] q_rx  [$];
   logic [7:0] fbuf  [$];

   int         m_bits   = 0;
   int         m_run    = 0;
   int         last_run = 0;
   int         t_first  = -1;
   int         t_last   = -1;
   int         done_cnt = 0;
   int         lane_bad = 0;
   logic [7:0] m_acc    = '0;

   // Cycle counter, stepped at each active edge.
   always @(posedge clk) cyc = cyc + 1;

   // Lane monitor: rebuilds bytes MSB first and measures valid runs.
   always @(negedge clk) begin
      if (!rstn) begin
         m_bits = 0;
         m_run  = 0;
      end else if (bus.p2s_dout[3] === 1'b1) begin
         if (m_run == 0) t_first = cyc;
         t_last = cyc;
         m_acc  = {m_acc[6:0], bus.p2s_dout[0]};
         m_bits = m_bits + 1;
         m_run  = m_run + 1;
         if (bus.p2s_dout[2:1] !== 2'b00) lane_bad = lane_bad + 1;
         if (m_bits == 8) begin
            q_rx.push_back(m_acc);
            m_bits = 0;
         end
      end else begin
         if (bus.p2s_dout[2:0] !== 3'b000) lane_bad = lane_bad + 1;
         if (m_run != 0) begin
            last_run = m_run;
            m_run    = 0;
         end
      end
      if (bus.tx_done === 1'b1) done_cnt = done_cnt + 1;
   end

   // Drives fbuf as one frame; returns the edge that samples the end.
   task automatic send_frame(output int e_cyc);
      foreach (fbuf[i]) begin
         @(posedge clk); #1;
         bus.p2s_din = {1'b1, fbuf[i]};
         if (i < MAX_BYTES) q_exp.push_back(fbuf[i]);
      end
      @(posedge clk); #1;
      bus.p2s_din = 9'h000;
      e_cyc = cyc + 1;
   endtask

   // Bounded wait for busy (sel 0) or tx_done (sel 1) to reach lvl.
   task automatic wait_for(input int sel, input logic lvl, input int limit,
                           input string name, output int t);
      bit hit;
      hit = 1'b0;
      t   = -1;
      for (int i = 0; i < limit && !hit; i++) begin
         @(negedge clk);
         if (((sel == 0) ? bus.busy : bus.tx_done) === lvl) begin
            hit = 1'b1;
            t   = cyc;
         end
      end
      if (!hit) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: no level %0b within %0d cycles", name, lvl, limit);
      end
   endtask

   // Pops every expected byte and compares it with the received one.
   task automatic scoreboard_drain(input string name);
      logic [7:0] e;
      logic [7:0] r;
      int         k;
      k = 0;
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front();
         n_cmp++;
         if (q_rx.size() == 0) begin
            n_fail++;
            $display("FAIL %s byte %0d: got nothing, expected %02h", name, k, e);
         end else begin
            r = q_rx.pop_front();
            if (r !== e) begin
               n_fail++;
               $display("FAIL %s byte %0d: got %02h, expected %02h", name, k, r, e);
            end
         end
         k++;
      end
      n_cmp++;
      if (q_rx.size() != 0) begin
         n_fail++;
         $display("FAIL %s extra: got %0d extra bytes, expected 0", name, q_rx.size());
      end
      q_rx.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.p2s_dout !== 4'h0) begin n_fail++; $display("FAIL reset_dout: got %h, expected 0", bus.p2s_dout); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
      n_cmp++; if (bus.tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_tx_done: got %b, expected 0", bus.tx_done); end
      n_cmp++; if (bus.frame_len !== '0) begin n_fail++; $display("FAIL reset_frame_len: got %0d, expected 0", bus.frame_len); end
      n_cmp++; if (bus.err_drop !== 1'b0) begin n_fail++; $display("FAIL reset_err_drop: got %b, expected 0", bus.err_drop); end
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0 || bus.p2s_dout !== 4'h0) begin n_fail++; $display("FAIL idle_after_reset: got busy %b dout %h, expected 0 0", bus.busy, bus.p2s_dout); end
   endtask

   task automatic test_single_byte();
      int e, tb, td, tl, d0;
      d0   = done_cnt;
      fbuf = {8'hA5};
      send_frame(e);
      wait_for(0, 1'b1, 20, "single_busy_rise", tb);
      wait_for(1, 1'b1, 200, "single_tx_done", td);
      wait_for(0, 1'b0, 100, "single_busy_fall", tl);
      n_cmp++; if (tb !== e + 1) begin n_fail++; $display("FAIL single_busy_rise: got cycle %0d, expected %0d", tb, e + 1); end
      n_cmp++; if (t_first !== e + 3) begin n_fail++; $display("FAIL single_first_bit: got cycle %0d, expected %0d", t_first, e + 3); end
      n_cmp++; if (td !== e + 11) begin n_fail++; $display("FAIL single_tx_done: got cycle %0d, expected %0d", td, e + 11); end
      n_cmp++; if (tl !== td + GAP_CYC) begin n_fail++; $display("FAIL single_busy_fall: got cycle %0d, expected %0d", tl, td + GAP_CYC); end
      n_cmp++; if (last_run !== 8) begin n_fail++; $display("FAIL single_run: got %0d, expected 8", last_run); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL single_done_pulses: got %0d, expected 1", done_cnt - d0); end
      n_cmp++; if (bus.frame_len !== 12'd1) begin n_fail++; $display("FAIL single_frame_len: got %0d, expected 1", bus.frame_len); end
      scoreboard_drain("single");
   endtask

   task automatic test_four_byte();
      int e, td, tl;
      fbuf = {8'h00, 8'hFF, 8'h3C, 8'h81};
      send_frame(e);
      wait_for(1, 1'b1, 300, "four_tx_done", td);
      wait_for(0, 1'b0, 100, "four_busy_fall", tl);
      n_cmp++; if (t_first !== e + 3) begin n_fail++; $display("FAIL four_first_bit: got cycle %0d, expected %0d", t_first, e + 3); end
      n_cmp++; if (t_last !== e + 34) begin n_fail++; $display("FAIL four_last_bit: got cycle %0d, expected %0d", t_last, e + 34); end
      n_cmp++; if (last_run !== 32) begin n_fail++; $display("FAIL four_run: got %0d, expected 32", last_run); end
      n_cmp++; if (bus.frame_len !== 12'd4) begin n_fail++; $display("FAIL four_frame_len: got %0d, expected 4", bus.frame_len); end
      n_cmp++; if (bus.err_drop !== 1'b0) begin n_fail++; $display("FAIL four_err_drop: got %b, expected 0", bus.err_drop); end
      scoreboard_drain("four");
   endtask

   task automatic test_gap();
      int e1, e2, td, tl, tlast1;
      fbuf = {8'h5A};
      send_frame(e1);
      wait_for(1, 1'b1, 200, "gap_tx_done1", td);
      wait_for(0, 1'b0, 100, "gap_busy_fall1", tl);
      tlast1 = t_last;
      n_cmp++; if (tl !== td + GAP_CYC) begin n_fail++; $display("FAIL gap_busy_hold: got cycle %0d, expected %0d", tl, td + GAP_CYC); end
      fbuf = {8'hC6};
      send_frame(e2);
      wait_for(1, 1'b1, 200, "gap_tx_done2", td);
      wait_for(0, 1'b0, 100, "gap_busy_fall2", tl);
      n_cmp++; if (t_first - tlast1 - 1 < GAP_CYC) begin n_fail++; $display("FAIL gap_idle: got %0d idle cycles, expected at least %0d", t_first - tlast1 - 1, GAP_CYC); end
      n_cmp++; if (t_first !== e2 + 3) begin n_fail++; $display("FAIL gap_second_start: got cycle %0d, expected %0d", t_first, e2 + 3); end
      scoreboard_drain("gap");
   endtask

   task automatic test_overflow();
      int e, td, tl;
      fbuf.delete();
      for (int i = 0; i < MAX_BYTES + 2; i++) fbuf.push_back(8'(i * 37 + 5));
      n_cmp++; if (bus.err_drop !== 1'b0) begin n_fail++; $display("FAIL ovf_err_pre: got %b, expected 0", bus.err_drop); end
      send_frame(e);
      wait_for(1, 1'b1, 8 * MAX_BYTES + 100, "ovf_tx_done", td);
      wait_for(0, 1'b0, 100, "ovf_busy_fall", tl);
      n_cmp++; if (bus.frame_len !== 12'd2048) begin n_fail++; $display("FAIL ovf_frame_len: got %0d, expected 2048", bus.frame_len); end
      n_cmp++; if (bus.err_drop !== 1'b1) begin n_fail++; $display("FAIL ovf_err_drop: got %b, expected 1", bus.err_drop); end
      n_cmp++; if (last_run !== 8 * MAX_BYTES) begin n_fail++; $display("FAIL ovf_run: got %0d, expected %0d", last_run, 8 * MAX_BYTES); end
      scoreboard_drain("ovf");
   endtask

   task automatic test_reset_mid_tx();
      int  e, e2, td, tl;
      bit  hit;
      fbuf = {8'hF0, 8'h0F, 8'hAA, 8'h55};
      send_frame(e);
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         if (cyc == e + 13) hit = 1'b1;
      end
      n_cmp++; if (!hit || bus.p2s_dout[3] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_active: got valid %b, expected 1", bus.p2s_dout[3]); end
      n_cmp++; if (bus.err_drop !== 1'b1) begin n_fail++; $display("FAIL rst_mid_err_pre: got %b, expected 1", bus.err_drop); end
      #1 rstn = 1'b0;
      #1;
      n_cmp++; if (bus.p2s_dout !== 4'h0) begin n_fail++; $display("FAIL rst_mid_dout: got %h, expected 0", bus.p2s_dout); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b, expected 0", bus.busy); end
      n_cmp++; if (bus.frame_len !== '0) begin n_fail++; $display("FAIL rst_mid_frame_len: got %0d, expected 0", bus.frame_len); end
      n_cmp++; if (bus.err_drop !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b, expected 0", bus.err_drop); end
      q_exp.delete();
      q_rx.delete();
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      fbuf = {8'h96};
      send_frame(e2);
      wait_for(1, 1'b1, 200, "rst_new_tx_done", td);
      wait_for(0, 1'b0, 100, "rst_new_busy_fall", tl);
      n_cmp++; if (t_first !== e2 + 3) begin n_fail++; $display("FAIL rst_new_first_bit: got cycle %0d, expected %0d", t_first, e2 + 3); end
      n_cmp++; if (last_run !== 8) begin n_fail++; $display("FAIL rst_new_run: got %0d, expected 8", last_run); end
      n_cmp++; if (bus.frame_len !== 12'd1) begin n_fail++; $display("FAIL rst_new_frame_len: got %0d, expected 1", bus.frame_len); end
      n_cmp++; if (bus.err_drop !== 1'b0) begin n_fail++; $display("FAIL rst_new_err: got %b, expected 0", bus.err_drop); end
      scoreboard_drain("rst_new");
   endtask

   task automatic test_busy_drop();
      int e, e2, tb, td, tl;
      fbuf = {8'h12, 8'h34, 8'h56, 8'h78};
      send_frame(e);
      n_cmp++; if (bus.err_drop !== 1'b0) begin n_fail++; $display("FAIL drop_err_pre: got %b, expected 0", bus.err_drop); end
      wait_for(0, 1'b1, 20, "drop_busy_rise", tb);
      repeat (4) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         bus.p2s_din = {1'b1, 8'hEE};
      end
      @(posedge clk); #1;
      bus.p2s_din = 9'h000;
      wait_for(1, 1'b1, 300, "drop_tx_done", td);
      wait_for(0, 1'b0, 100, "drop_busy_fall", tl);
      n_cmp++; if (bus.err_drop !== 1'b1) begin n_fail++; $display("FAIL drop_err: got %b, expected 1", bus.err_drop); end
      n_cmp++; if (last_run !== 32) begin n_fail++; $display("FAIL drop_run: got %0d, expected 32", last_run); end
      n_cmp++; if (bus.frame_len !== 12'd4) begin n_fail++; $display("FAIL drop_frame_len: got %0d, expected 4", bus.frame_len); end
      scoreboard_drain("drop");
      fbuf = {8'hC3};
      send_frame(e2);
      wait_for(1, 1'b1, 200, "drop_next_tx_done", td);
      wait_for(0, 1'b0, 100, "drop_next_busy_fall", tl);
      n_cmp++; if (t_first !== e2 + 3) begin n_fail++; $display("FAIL drop_next_first_bit: got cycle %0d, expected %0d", t_first, e2 + 3); end
      n_cmp++; if (last_run !== 8) begin n_fail++; $display("FAIL drop_next_run: got %0d, expected 8", last_run); end
      n_cmp++; if (bus.err_drop !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: got %b, expected 1", bus.err_drop); end
      scoreboard_drain("drop_next");
   endtask

   initial begin
      bus.p2s_din = 9'h000;
      test_reset();
      test_single_byte();
      test_four_byte();
      test_gap();
      test_overflow();
      test_reset_mid_tx();
      test_busy_drop();
      n_cmp++;
      if (lane_bad !== 0) begin
         n_fail++;
         $display("FAIL idle_lane: got %0d bad lane cycles, expected 0", lane_bad);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
      $finish;
   end

   // Hard stop in case the run stalls somewhere unexpected.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
